// File: rtl/sccb_cfg_pkg.sv
// sccb_cfg_pkg: sequencer state encoding and ROM marker constants shared by the SCCB config block.
package sccb_cfg_pkg;
   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, WR_CMD, WR_WAIT, RD_CMD, RD_WAIT, CHECK, DELAY, DONE
   } state_t;
   localparam logic [15:0] END       = 16'hFFFF;
   localparam logic [7:0]  DELAY_PFX = 8'hFE;
endpackage

// File: rtl/ms_timer.sv
// ms_timer: millisecond down-counter; load restarts the prescaler, expired is high once the count reaches zero.
module ms_timer #(
   parameter int DIV = 25125
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       count,
   input  logic [7:0] ms_val,
   output logic       expired
);
   localparam int PW = (DIV < 2) ? 1 : $clog2(DIV);
   logic [PW-1:0] pre_q, pre_d;
   logic [7:0]    ms_q, ms_d;
   logic          tick;
   assign tick    = count && (pre_q == PW'(DIV - 1));
   assign expired = ms_q == 8'd0;
   always_comb begin
      pre_d = (load || tick) ? '0 : count ? pre_q + 1'b1 : pre_q;
      ms_d  = load ? ms_val : (tick && !expired) ? ms_q - 8'd1 : ms_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
         ms_q  <= '0;
      end else begin
         pre_q <= pre_d;
         ms_q  <= ms_d;
      end
   end
endmodule

// File: rtl/sccb_config_seq.sv
// sccb_config_seq: walks a register ROM issuing SCCB writes, optional readback verify with retries, and ms delays.
module sccb_config_seq
   import sccb_cfg_pkg::*;
#(
   parameter int CLK_FREQ  = 25125000,
   parameter int ROM_AW    = 8,
   parameter int VERIFY    = 1,
   parameter int MAX_RETRY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   input  logic              sccb_ready,
   output logic              sccb_start,
   output logic              sccb_rw,
   output logic [7:0]        sccb_addr,
   output logic [7:0]        sccb_wdata,
   input  logic [7:0]        sccb_rdata,
   input  logic              sccb_rvalid,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ROM_AW-1:0] err_addr
);
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   state_t            state_q, state_d;
   logic [ROM_AW-1:0] addr_q, addr_d, eaddr_q, eaddr_d;
   logic [RW-1:0]     retry_q, retry_d;
   logic [7:0]        rdata_q, rdata_d, saddr_q, saddr_d, wdata_q, wdata_d;
   logic              start_q, start_d, rw_q, rw_d, done_q, done_d, err_q, err_d;
   logic              is_end, is_dly, last, wr_ok, match, spent, adv, fail, tmr_exp;
   assign is_end = rom_data == END;
   assign is_dly = rom_data[15:8] == DELAY_PFX;
   assign last   = &addr_q;
   // start_q is high exactly on the first WR_WAIT cycle, when the master's ready is not yet meaningful
   assign wr_ok  = !start_q && sccb_ready;
   assign match  = rdata_q == wdata_q;
   assign spent  = retry_q >= RW'(MAX_RETRY);
   assign fail   = state_q == CHECK && !match && spent;
   assign adv    = (state_q == DECODE && is_dly) || (state_q == WR_WAIT && wr_ok && VERIFY == 0)
                 || (state_q == CHECK && (match || spent));
   ms_timer #(.DIV(CLK_FREQ / 1000)) u_tmr (
      .clk     (clk),
      .rst     (rst),
      .load    (state_q == DECODE && is_dly),
      .count   (state_q == DELAY),
      .ms_val  (rom_data[7:0]),
      .expired (tmr_exp)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         eaddr_q <= '0;
         retry_q <= '0;
         rdata_q <= '0;
         saddr_q <= '0;
         wdata_q <= '0;
         start_q <= 1'b0;
         rw_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         eaddr_q <= eaddr_d;
         retry_q <= retry_d;
         rdata_q <= rdata_d;
         saddr_q <= saddr_d;
         wdata_q <= wdata_d;
         start_q <= start_d;
         rw_q    <= rw_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end
   // any advance past the top ROM address ends the sequence instead of wrapping
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? FETCH : IDLE;
         FETCH:   state_d = DECODE;
         DECODE:  state_d = is_end ? DONE : is_dly ? (last ? DONE : DELAY) : WR_CMD;
         WR_CMD:  state_d = sccb_ready ? WR_WAIT : WR_CMD;
         WR_WAIT: state_d = !wr_ok ? WR_WAIT : (VERIFY != 0) ? RD_CMD : last ? DONE : FETCH;
         RD_CMD:  state_d = sccb_ready ? RD_WAIT : RD_CMD;
         RD_WAIT: state_d = sccb_rvalid ? CHECK : RD_WAIT;
         CHECK:   state_d = !(match || spent) ? WR_CMD : last ? DONE : FETCH;
         DELAY:   state_d = tmr_exp ? FETCH : DELAY;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end
   always_comb begin
      addr_d  = adv ? (last ? addr_q : addr_q + 1'b1) : addr_q;
      retry_d = (state_q != CHECK) ? retry_q : (match || spent) ? '0 : retry_q + 1'b1;
      rdata_d = (state_q == RD_WAIT && sccb_rvalid) ? sccb_rdata : rdata_q;
      start_d = !abort && sccb_ready && (state_q == WR_CMD || state_q == RD_CMD);
      rw_d    = start_d ? state_q == RD_CMD : rw_q;
      saddr_d = (start_d && state_q == WR_CMD) ? rom_data[15:8] : saddr_q;
      wdata_d = (start_d && state_q == WR_CMD) ? rom_data[7:0] : wdata_q;
      done_d  = !abort && (state_q == DONE || done_q);
      err_d   = err_q || fail || (adv && last);
      eaddr_d = ((fail || (adv && last)) && !err_q) ? addr_q : eaddr_q;
      if (state_q == IDLE && start && !abort) begin
         addr_d  = '0;
         retry_d = '0;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end
   end
   assign rom_addr   = addr_q;
   assign sccb_start = start_q;
   assign sccb_rw    = rw_q;
   assign sccb_addr  = saddr_q;
   assign sccb_wdata = wdata_q;
   assign busy       = state_q != IDLE;
   assign done       = done_q;
   assign error      = err_q;
   assign err_addr   = eaddr_q;
endmodule

// File: tb/tb_sccb_config_seq.sv
// tb_sccb_config_seq: directed checks of two sequencer instances (write-only small ROM, verify) against ROM and SCCB master models.
module tb_sccb_config_seq;
   logic        clk = 1'b0, rst = 1'b1;
   logic        start0 = 1'b0, start1 = 1'b0, abort0 = 1'b0, abort1 = 1'b0, zero1 = 1'b0;
   logic        rdy0, rdy1, rv0, rv1, isrd0, isrd1, pst0, pst1;
   logic [15:0] rdat0, rdat1;
   logic [7:0]  rd0, rd1, a0, a1, w0, w1, ra1, ea1;
   logic [1:0]  ra0, ea0;
   logic        st0, st1, rw0, rw1, bz0, bz1, dn0, dn1, er0, er1;
   logic [15:0] rom0 [4];
   logic [15:0] rom1 [256];
   logic [7:0]  wla0 [64], wld0 [64], wla1 [64], wld1 [64];
   int          cnt0, cnt1, nwr0, nwr1, nrd0, nrd1, nst0, nst1, dbl0, dbl1;
   int          nerr = 0, nchk = 0;
   always #5 clk = ~clk;
   sccb_config_seq #(.CLK_FREQ(10000), .ROM_AW(2), .VERIFY(0), .MAX_RETRY(2)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort0), .rom_addr(ra0), .rom_data(rdat0),
      .sccb_ready(rdy0), .sccb_start(st0), .sccb_rw(rw0), .sccb_addr(a0), .sccb_wdata(w0),
      .sccb_rdata(rd0), .sccb_rvalid(rv0), .busy(bz0), .done(dn0), .error(er0), .err_addr(ea0)
   );
   sccb_config_seq #(.CLK_FREQ(10000), .ROM_AW(8), .VERIFY(1), .MAX_RETRY(2)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .rom_addr(ra1), .rom_data(rdat1),
      .sccb_ready(rdy1), .sccb_start(st1), .sccb_rw(rw1), .sccb_addr(a1), .sccb_wdata(w1),
      .sccb_rdata(rd1), .sccb_rvalid(rv1), .busy(bz1), .done(dn1), .error(er1), .err_addr(ea1)
   );
   // one-cycle ROM and an SCCB master that is busy for 3 cycles per command; reads echo the held wdata
   always @(posedge clk) begin
      rdat0 <= rom0[ra0];
      rv0   <= 1'b0;
      pst0  <= st0;
      if (rst) begin
         rdy0 <= 1'b1; cnt0 <= 0; nwr0 <= 0; nrd0 <= 0; nst0 <= 0; dbl0 <= 0; isrd0 <= 1'b0; rd0 <= '0;
      end else if (st0) begin
         nst0 <= nst0 + 1; dbl0 <= dbl0 + (pst0 ? 1 : 0); rdy0 <= 1'b0; cnt0 <= 3; isrd0 <= rw0;
         if (rw0) nrd0 <= nrd0 + 1;
         else begin wla0[nwr0[5:0]] <= a0; wld0[nwr0[5:0]] <= w0; nwr0 <= nwr0 + 1; end
      end else if (cnt0 == 1) begin
         rdy0 <= 1'b1; cnt0 <= 0; rv0 <= isrd0; rd0 <= w0;
      end else if (cnt0 > 1) cnt0 <= cnt0 - 1;
   end
   always @(posedge clk) begin
      rdat1 <= rom1[ra1];
      rv1   <= 1'b0;
      pst1  <= st1;
      if (rst) begin
         rdy1 <= 1'b1; cnt1 <= 0; nwr1 <= 0; nrd1 <= 0; nst1 <= 0; dbl1 <= 0; isrd1 <= 1'b0; rd1 <= '0;
      end else if (st1) begin
         nst1 <= nst1 + 1; dbl1 <= dbl1 + (pst1 ? 1 : 0); rdy1 <= 1'b0; cnt1 <= 3; isrd1 <= rw1;
         if (rw1) nrd1 <= nrd1 + 1;
         else begin wla1[nwr1[5:0]] <= a1; wld1[nwr1[5:0]] <= w1; nwr1 <= nwr1 + 1; end
      end else if (cnt1 == 1) begin
         rdy1 <= 1'b1; cnt1 <= 0; rv1 <= isrd1; rd1 <= (zero1 && a1 == 8'h3A) ? 8'h00 : w1;
      end else if (cnt1 > 1) cnt1 <= cnt1 - 1;
   end
   function automatic logic dn(input int k); return k != 0 ? dn1 : dn0; endfunction
   function automatic logic bz(input int k); return k != 0 ? bz1 : bz0; endfunction
   task automatic set_start(input int k, input logic v);
      if (k != 0) start1 = v; else start0 = v;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // pulse start, optionally re-pulse it at loop step poke, count busy cycles until done
   task automatic run(input int k, input int poke, output int cyc);
      cyc = 0;
      set_start(k, 1'b1);
      @(negedge clk);
      for (int i = 1; i <= 400 && !dn(k); i++) begin
         set_start(k, i == poke);
         if (bz(k)) cyc++;
         @(negedge clk);
      end
      set_start(k, 1'b0);
      chk($sformatf("done%0d", k), 32'(dn(k)), 32'd1);
   endtask
   initial begin
      int c, c2, w, r, s;
      foreach (rom1[i]) rom1[i] = 16'hFFFF;
      rom0 = '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF};
      repeat (3) @(negedge clk);
      chk("rst_busy0", 32'(bz0), 0);
      chk("rst_done0", 32'(dn0), 0);
      chk("rst_err0", 32'(er0), 0);
      chk("rst_start0", 32'(st0), 0);
      chk("rst_addr0", 32'(ra0), 0);
      chk("rst_busy1", 32'(bz1), 0);
      chk("rst_eaddr1", 32'(ea1), 0);
      chk("rst_wdata1", 32'(w1), 0);
      rst = 1'b0;
      @(negedge clk);
      w = nwr0;
      run(0, 0, c);
      chk("a_nwr", 32'(nwr0 - w), 2);
      chk("a_w0_addr", 32'(wla0[w]), 32'h12);
      chk("a_w0_data", 32'(wld0[w]), 32'h80);
      chk("a_w1_addr", 32'(wla0[w + 1]), 32'h11);
      chk("a_w1_data", 32'(wld0[w + 1]), 32'h01);
      chk("a_nrd", 32'(nrd0), 0);
      chk("a_err", 32'(er0), 0);
      chk("a_busy", 32'(bz0), 0);
      rom0 = '{16'hFE03, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      w = nwr0;
      run(0, 0, c);
      chk("b_delay_busy_cycles_35_37", 32'(c >= 35 && c <= 37), 1);
      chk("b_nwr", 32'(nwr0 - w), 0);
      chk("b_err", 32'(er0), 0);
      rom0 = '{16'h1280, 16'h1101, 16'hFE00, 16'h1234};
      w = nwr0;
      run(0, 0, c);
      chk("c_wrap_err", 32'(er0), 1);
      chk("c_wrap_eaddr", 32'(ea0), 3);
      chk("c_nwr", 32'(nwr0 - w), 3);
      chk("c_w2_addr", 32'(wla0[w + 2]), 32'h12);
      chk("c_w2_data", 32'(wld0[w + 2]), 32'h34);
      rom0[0] = 16'hFFFF;
      w = nwr0;
      run(0, 0, c);
      chk("c2_err_cleared", 32'(er0), 0);
      chk("c2_nwr", 32'(nwr0 - w), 0);
      zero1   = 1'b1;
      rom1[0] = 16'h3A04;
      rom1[1] = 16'h5511;
      w = nwr1;
      r = nrd1;
      run(1, 0, c);
      zero1 = 1'b0;
      chk("d_nwr", 32'(nwr1 - w), 4);
      chk("d_nrd", 32'(nrd1 - r), 4);
      chk("d_err", 32'(er1), 1);
      chk("d_eaddr", 32'(ea1), 0);
      chk("d_w2_addr", 32'(wla1[w + 2]), 32'h3A);
      chk("d_w2_data", 32'(wld1[w + 2]), 32'h04);
      chk("d_w3_addr", 32'(wla1[w + 3]), 32'h55);
      chk("d_w3_data", 32'(wld1[w + 3]), 32'h11);
      rom1[0] = 16'h1201;
      rom1[1] = 16'h1302;
      run(1, 0, c);
      chk("e_err_cleared", 32'(er1), 0);
      w = nwr1;
      run(1, 5, c2);
      chk("e_poke_cycles", 32'(c2), 32'(c));
      chk("e_poke_nwr", 32'(nwr1 - w), 2);
      rom1[0] = 16'h2233;
      rom1[1] = 16'hFFFF;
      r = nrd1;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int i = 0; i < 100 && nrd1 == r; i++) @(negedge clk);
      chk("f_read_issued", 32'(nrd1 - r), 1);
      abort1 = 1'b1;
      @(negedge clk);
      abort1 = 1'b0;
      chk("f_abort_busy", 32'(bz1), 0);
      chk("f_abort_done", 32'(dn1), 0);
      s = nst1;
      repeat (10) @(negedge clk);
      chk("f_no_more_start", 32'(nst1 - s), 0);
      chk("f_still_idle", 32'(bz1), 0);
      chk("f_done_low", 32'(dn1), 0);
      chk("dbl_start0", 32'(dbl0), 0);
      chk("dbl_start1", 32'(dbl1), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/sccb_config_seq.md
SCCB_CONFIG_SEQ -- requirements
Module: sccb_config_seq

Interface
REQ-001 Parameter CLK_FREQ, default 25125000, system clock frequency in Hz, used to derive the 1 ms tick.
REQ-002 Parameter ROM_AW, default 8, ROM address width; the ROM holds up to 2^ROM_AW 16-bit entries.
REQ-003 Parameter VERIFY, default 1, 1 = read back and compare every register write, 0 = write only.
REQ-004 Parameter MAX_RETRY, default 2, number of re-writes allowed per entry after a readback mismatch.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 start  in  1  pulse; begins a sequence from ROM address 0 when idle.
REQ-008 abort  in  1  pulse; terminates any sequence in progress.
REQ-009 rom_addr  out  ROM_AW  ROM read address.
REQ-010 rom_data  in  16  ROM entry {reg_addr[15:8], value[7:0]}, valid one cycle after rom_addr changes.
REQ-011 sccb_ready  in  1  SCCB master idle and able to accept a command.
REQ-012 sccb_start  out  1  one-cycle command strobe to the SCCB master.
REQ-013 sccb_rw  out  1  0 = write, 1 = read; qualified by sccb_start.
REQ-014 sccb_addr, sccb_wdata  out  8 each  register address and write data; held stable until the next command.
REQ-015 sccb_rdata  in  8  readback data, qualified by sccb_rvalid.
REQ-016 sccb_rvalid  in  1  one-cycle pulse marking completion of a read.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  level; set on sequence end and cleared by the next accepted start, by abort, or by rst.
REQ-019 error  out  1  level; set on verify failure or ROM wrap, cleared by the next accepted start.
REQ-020 err_addr  out  ROM_AW  address of the first failing entry; captured when error first sets.

Function
REQ-021 States: IDLE, FETCH, DECODE, WR_CMD, WR_WAIT, RD_CMD, RD_WAIT, CHECK, DELAY, DONE.
REQ-022 IDLE: start=1 -> FETCH; rom_addr<=0, done<=0, error<=0, retry count<=0; start while busy SHALL be ignored.
REQ-023 FETCH: wait exactly one cycle for the ROM latency, then go to DECODE.
REQ-024 DECODE, entry 16'hFFFF: go to DONE.
REQ-025 DECODE, entry 16'hFExx: load the ms counter with xx, increment rom_addr, go to DELAY; xx=0 gives a delay of one cycle.
REQ-026 DECODE, any other entry: go to WR_CMD.
REQ-027 WR_CMD: wait for sccb_ready=1, then pulse sccb_start with sccb_rw=0 and addr/wdata taken from rom_data, then go to WR_WAIT.
REQ-028 WR_WAIT: ignore sccb_ready on the first cycle, then wait for sccb_ready=1.
REQ-029 WR_WAIT exit: if VERIFY=1 go to RD_CMD; otherwise increment rom_addr and go to FETCH.
REQ-030 RD_CMD: wait for sccb_ready=1, then pulse sccb_start with sccb_rw=1 and the same sccb_addr, then go to RD_WAIT.
REQ-031 RD_WAIT: wait for sccb_rvalid, latch sccb_rdata, then go to CHECK.
REQ-032 CHECK, readback equal to value: clear the retry count, increment rom_addr, go to FETCH.
REQ-033 CHECK, mismatch with retries below MAX_RETRY: increment the retry count and go to WR_CMD.
REQ-034 CHECK, mismatch with retries exhausted: set error, capture err_addr, clear the retry count, increment rom_addr, go to FETCH; the sequence continues.
REQ-035 DELAY: a prescaler generates a tick every CLK_FREQ/1000 clocks, restarting on DELAY entry; each tick decrements the ms counter; at 0 go to FETCH.
REQ-036 ROM wrap: an increment from 2^ROM_AW-1 SHALL end the sequence (go to DONE), set error, and set err_addr to 2^ROM_AW-1.
REQ-037 DONE: done<=1, go to IDLE next cycle.
REQ-038 abort: takes priority over all transitions; go to IDLE next cycle with sccb_start=0 and done=0; error and err_addr are kept.
REQ-039 sccb_start SHALL never be high for two consecutive cycles.

Reset
REQ-040 rst=1: state<=IDLE and rom_addr, counters, sccb_* outputs, done, error and err_addr all <=0; rst overrides abort and start in the same cycle.

Structure
REQ-041 A shared package sccb_cfg_pkg SHALL hold the state encoding and the marker constants END=16'hFFFF and DELAY prefix=8'hFE.
REQ-042 The ms delay generator SHALL be the sub-module ms_timer (inputs load and count; output expired).

Verification
REQ-043 ROM {12 80, 11 01, FFFF}, VERIFY=0: two writes with 12/80 then 11/01, done=1 ~2 cycles after the last ready, error=0.
REQ-044 ROM {FE03, FFFF}, CLK_FREQ=10000: DELAY lasts 30 ticks +/-1 cycle, then done.
REQ-045 VERIFY=1, MAX_RETRY=2, readback always 00 for entry 0 = 3A04: three writes and three reads, then error=1, err_addr=0, and the sequence continues to done.
REQ-046 abort during RD_WAIT: busy=0 on the next cycle, no further sccb_start, done=0.
REQ-047 ROM_AW=2 with no FFFF entry: done=1, error=1, err_addr=3.
REQ-048 start pulsed while busy: no restart, and rom_addr follows the sequence unchanged.
